// File: rtl/mmio_uart_tx.sv
// MMIO-driven 8N1 UART transmitter: each bus word goes out as BUS_WIDTH/8 bytes, LSB byte first,
// with a one-entry holding register, a sticky overflow flag and a completed-word counter.
module mmio_uart_tx #(
    parameter int BUS_WIDTH    = 32,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] mem_map_io,
    input  logic                 io_wr_strobe,
    input  logic                 ovf_clr,
    output logic                 tx,
    output logic                 busy,
    output logic                 pending,
    output logic                 overflow,
    output logic [15:0]          words_sent
);

    localparam int                BYTES     = BUS_WIDTH / 8;
    localparam int                BYTE_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [15:0]       BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e                 state_q, state_d;
    logic [15:0]            baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [BYTE_W-1:0]      byte_q, byte_d;
    logic [BUS_WIDTH-1:0]   shift_q, shift_d;
    logic [BUS_WIDTH-1:0]   hold_q, hold_d;
    logic                   pending_q, pending_d;
    logic                   overflow_q, overflow_d;
    logic [15:0]            words_q, words_d;
    logic                   tx_q, tx_d;
    logic                   bit_done;
    logic                   freed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
            words_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            words_q    <= words_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        words_d    = words_q;
        freed      = 1'b0;
        bit_done   = (baud_q == BAUD_LAST);

        if (state_q != IDLE) begin
            baud_d = bit_done ? '0 : baud_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                // A word captured on the last stop edge waits here one cycle in the holding register.
                if (pending_q) begin
                    shift_d   = hold_q;
                    pending_d = 1'b0;
                    freed     = 1'b1;
                    state_d   = START;
                    baud_d    = '0;
                    byte_d    = '0;
                end else if (io_wr_strobe) begin
                    shift_d = mem_map_io;
                    state_d = START;
                    baud_d  = '0;
                    byte_d  = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    // Shifting the whole word leaves the next byte in the low 8 bits.
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (byte_q != BYTE_LAST) begin
                        byte_d  = byte_q + BYTE_W'(1);
                        state_d = START;
                    end else begin
                        words_d = words_q + 16'd1;
                        byte_d  = '0;
                        if (pending_q) begin
                            shift_d   = hold_q;
                            pending_d = 1'b0;
                            freed     = 1'b1;
                            state_d   = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        // Setting overflow is evaluated after the clear so a simultaneous overflow wins.
        if (io_wr_strobe && !(state_q == IDLE && !pending_q)) begin
            if (!pending_q || freed) begin
                hold_d    = mem_map_io;
                pending_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) || pending_q;
    assign pending    = pending_q;
    assign overflow   = overflow_q;
    assign words_sent = words_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx at CLKS_PER_BIT=4: frame timing, holding register,
// overflow, edge-coincident strobes, asynchronous reset and counter wrap.
module tb_mmio_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mem_map_io = '0;
    logic        io_wr_strobe = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        tx, busy, pending, overflow;
    logic [15:0] words_sent;

    int total = 0;
    int bad   = 0;

    mmio_uart_tx #(.BUS_WIDTH(32), .CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_map_io   (mem_map_io),
        .io_wr_strobe (io_wr_strobe),
        .ovf_clr      (ovf_clr),
        .tx           (tx),
        .busy         (busy),
        .pending      (pending),
        .overflow     (overflow),
        .words_sent   (words_sent)
    );

    always #5 clk = ~clk;

    task automatic strobe_word(input logic [31:0] w);
        @(negedge clk);
        mem_map_io   = w;
        io_wr_strobe = 1'b1;
        @(posedge clk);
        #1;
        io_wr_strobe = 1'b0;
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns at the last cycle of the stop bit; waited==1 means the start bit followed immediately.
    task automatic rx_byte(output logic [7:0] b, output int waited, output logic framed);
        logic start_ok, stop_ok;
        b = '0;
        waited = 0;
        framed = 1'b0;
        do begin
            @(negedge clk);
            waited++;
        end while (tx !== 1'b0 && waited < 400);
        if (tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            start_ok = (tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            stop_ok = (tx === 1'b1);
            repeat (CPB / 2 - 1) @(negedge clk);
            framed = start_ok && stop_ok;
        end
    endtask

    task automatic rx_word(output logic [31:0] w, output int first_wait, output logic ok);
        logic [7:0] b;
        int         wt;
        logic       f;
        ok = 1'b1;
        w  = '0;
        first_wait = 0;
        for (int k = 0; k < 4; k++) begin
            rx_byte(b, wt, f);
            w[k*8 +: 8] = b;
            if (k == 0) first_wait = wt;
            else if (wt != 1) ok = 1'b0;
            if (!f) ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #2;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b exp=0", pending); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        total++; if (words_sent !== 16'h0) begin bad++; $display("FAIL reset_words got=%h exp=0000", words_sent); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single;
        logic [39:0] frame;
        int errs, first_err;
        frame = {10'b1000000000, 10'b1000000000, 10'b1000000000, 10'b1101001010};
        errs = 0;
        first_err = -1;
        pulse_reset();
        @(negedge clk);
        mem_map_io   = 32'h000000A5;
        io_wr_strobe = 1'b1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL single_pre_edge_tx got=%b exp=1", tx); end
        @(posedge clk);
        #1;
        io_wr_strobe = 1'b0;
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL single_latency_tx got=%b exp=0", tx); end
        for (int t = 0; t < 40 * CPB; t++) begin
            @(negedge clk);
            if (tx !== frame[t / CPB]) begin
                errs++;
                if (first_err < 0) first_err = t;
            end
        end
        total++; if (errs != 0) begin bad++; $display("FAIL single_waveform got=%0d bad cycles (first at %0d) exp=0", errs, first_err); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_last_cycle got=%b exp=1", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b exp=0", busy); end
        total++; if (words_sent !== 16'd1) begin bad++; $display("FAIL single_words got=%h exp=0001", words_sent); end
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL single_idle_tx got=%b exp=1", tx); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] got;
        logic        gapless, framed_all;
        logic [7:0]  b;
        int          wt;
        logic        f;
        got = '0;
        gapless = 1'b1;
        framed_all = 1'b1;
        pulse_reset();
        strobe_word(32'h11223344);
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    rx_byte(b, wt, f);
                    got[k*8 +: 8] = b;
                    if (k > 0 && wt != 1) gapless = 1'b0;
                    if (!f) framed_all = 1'b0;
                end
            end
            begin
                repeat (9) @(posedge clk);
                strobe_word(32'hDEADBEEF);
                total++; if (pending !== 1'b1) begin bad++; $display("FAIL b2b_pending got=%b exp=1", pending); end
            end
        join
        total++; if (got !== 64'hDEADBEEF11223344) begin bad++; $display("FAIL b2b_bytes got=%h exp=deadbeef11223344", got); end
        total++; if (!(gapless && framed_all)) begin bad++; $display("FAIL b2b_gapless_framing got=%b%b exp=11", gapless, framed_all); end
        @(negedge clk);
        total++; if (words_sent !== 16'd2) begin bad++; $display("FAIL b2b_words got=%h exp=0002", words_sent); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_overflow got=%b exp=0", overflow); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_overflow;
        logic [63:0] got;
        logic        ok_all;
        logic [31:0] w;
        int          wt;
        logic        ok;
        got = '0;
        ok_all = 1'b1;
        pulse_reset();
        strobe_word(32'h00000001);
        fork
            begin
                for (int k = 0; k < 2; k++) begin
                    rx_word(w, wt, ok);
                    got[k*32 +: 32] = w;
                    if (!ok) ok_all = 1'b0;
                end
            end
            begin
                repeat (3) @(posedge clk);
                strobe_word(32'h00000002);
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_after_second got=%b exp=0", overflow); end
                repeat (3) @(posedge clk);
                strobe_word(32'h00000003);
                total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_after_third got=%b exp=1", overflow); end
                total++; if (pending !== 1'b1) begin bad++; $display("FAIL ovf_pending got=%b exp=1", pending); end
                @(negedge clk);
                ovf_clr = 1'b1;
                @(posedge clk);
                #1 ovf_clr = 1'b0;
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
                @(negedge clk);
                mem_map_io   = 32'h00000004;
                io_wr_strobe = 1'b1;
                ovf_clr      = 1'b1;
                @(posedge clk);
                #1;
                io_wr_strobe = 1'b0;
                ovf_clr      = 1'b0;
                total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_beats_clear got=%b exp=1", overflow); end
            end
        join
        total++; if (got !== 64'h0000000200000001) begin bad++; $display("FAIL ovf_words_sent_data got=%h exp=0000000200000001", got); end
        total++; if (!ok_all) begin bad++; $display("FAIL ovf_framing got=%b exp=1", ok_all); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovf_no_third_word got=%b exp=0", busy); end
        total++; if (words_sent !== 16'd2) begin bad++; $display("FAIL ovf_words got=%h exp=0002", words_sent); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        @(negedge clk);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_final_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_coincidence;
        logic [31:0] w;
        int          wt;
        logic        ok;
        // Pending empty: strobe lands on the edge that completes the last stop bit.
        pulse_reset();
        strobe_word(32'hCAFE0001);
        repeat (40 * CPB - 1) @(negedge clk);
        strobe_word(32'h5A5A0F0F);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL coin0_overflow got=%b exp=0", overflow); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL coin0_busy got=%b exp=1", busy); end
        rx_word(w, wt, ok);
        total++; if (w !== 32'h5A5A0F0F || !ok) begin bad++; $display("FAIL coin0_word got=%h ok=%b exp=5a5a0f0f ok=1", w, ok); end
        @(negedge clk);
        total++; if (words_sent !== 16'd2) begin bad++; $display("FAIL coin0_words got=%h exp=0002", words_sent); end
        // Pending full: strobe lands on the edge that frees the holding register.
        pulse_reset();
        strobe_word(32'h01020304);
        repeat (9) @(negedge clk);
        strobe_word(32'hA1B2C3D4);
        repeat (40 * CPB - 11) @(negedge clk);
        strobe_word(32'h0BADF00D);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL coin1_overflow got=%b exp=0", overflow); end
        total++; if (pending !== 1'b1) begin bad++; $display("FAIL coin1_pending got=%b exp=1", pending); end
        rx_word(w, wt, ok);
        total++; if (w !== 32'hA1B2C3D4 || !ok || wt != 1) begin bad++; $display("FAIL coin1_held_word got=%h ok=%b wait=%0d exp=a1b2c3d4 ok=1 wait=1", w, ok, wt); end
        rx_word(w, wt, ok);
        total++; if (w !== 32'h0BADF00D || !ok || wt != 1) begin bad++; $display("FAIL coin1_new_word got=%h ok=%b wait=%0d exp=0badf00d ok=1 wait=1", w, ok, wt); end
        @(negedge clk);
        total++; if (words_sent !== 16'd3 || overflow !== 1'b0) begin bad++; $display("FAIL coin1_final got=%h/%b exp=0003/0", words_sent, overflow); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] w;
        int          wt;
        logic        ok;
        strobe_word(32'h12345678);
        strobe_word(32'h55555555);
        strobe_word(32'h66666666);
        repeat (90) @(negedge clk);
        total++; if (tx !== 1'b0 || overflow !== 1'b1) begin bad++; $display("FAIL midreset_pre got=%b/%b exp=0/1", tx, overflow); end
        #2 rst = 1'b1;
        #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL midreset_tx got=%b exp=1", tx); end
        total++; if (busy !== 1'b0 || pending !== 1'b0) begin bad++; $display("FAIL midreset_busy_pending got=%b%b exp=00", busy, pending); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL midreset_overflow got=%b exp=0", overflow); end
        total++; if (words_sent !== 16'h0) begin bad++; $display("FAIL midreset_words got=%h exp=0000", words_sent); end
        @(negedge clk);
        rst = 1'b0;
        strobe_word(32'h000000FF);
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL postreset_latency got=%b exp=0", tx); end
        rx_word(w, wt, ok);
        total++; if (w !== 32'h000000FF || !ok) begin bad++; $display("FAIL postreset_word got=%h ok=%b exp=000000ff ok=1", w, ok); end
        @(negedge clk);
        total++; if (words_sent !== 16'd1 || busy !== 1'b0) begin bad++; $display("FAIL postreset_done got=%h/%b exp=0001/0", words_sent, busy); end
    endtask

    task automatic test_wrap;
        logic [31:0] w;
        int          wt;
        logic        ok;
        pulse_reset();
        @(negedge clk);
        force dut.words_q = 16'hFFFF;
        @(negedge clk);
        release dut.words_q;
        total++; if (words_sent !== 16'hFFFF) begin bad++; $display("FAIL wrap_preset got=%h exp=ffff", words_sent); end
        strobe_word(32'h80000001);
        rx_word(w, wt, ok);
        total++; if (w !== 32'h80000001 || !ok) begin bad++; $display("FAIL wrap_word got=%h ok=%b exp=80000001 ok=1", w, ok); end
        @(negedge clk);
        total++; if (words_sent !== 16'h0000) begin bad++; $display("FAIL wrap_count got=%h exp=0000", words_sent); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_coincidence();
        test_reset_midframe();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter BUS_WIDTH, default 32: width of the memory-mapped I/O word.
REQ-002 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal values are 2 to 65535.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: reset, asynchronous and active-high.
REQ-005 mem_map_io  input  BUS_WIDTH: memory-mapped I/O output word written by the core.
REQ-006 io_wr_strobe  input  1: one-cycle pulse; the core wrote mem_map_io this cycle (address 64 with write enable asserted).
REQ-007 ovf_clr  input  1: clears the sticky overflow flag.
REQ-008 tx  output  1: serial line, 8N1 format, idle high.
REQ-009 busy  output  1: high while a frame is in flight or a word is pending.
REQ-010 pending  output  1: high while the one-entry holding register is occupied.
REQ-011 overflow  output  1: sticky flag; a strobe arrived while the holding register was full.
REQ-012 words_sent  output  16: count of completed words; wraps from 0xFFFF to 0x0000.

Function
REQ-013 The block SHALL serialise each accepted word as 4 bytes, least-significant byte first; each byte is sent as 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1).
REQ-014 Each bit SHALL hold tx for exactly CLKS_PER_BIT cycles, timed by a baud counter that reloads on every bit boundary.
REQ-015 The FSM SHALL have four states: IDLE, START, DATA, STOP.
- IDLE->START on an accepted strobe.
- START->DATA after one bit time.
- DATA->STOP after data bit 7.
- STOP->START if bytes remain or a word is pending.
- STOP->IDLE otherwise.
REQ-016 A strobe sampled in IDLE SHALL load mem_map_io into the shift register; tx SHALL go low at the next rising edge (1-cycle latency).
REQ-017 A strobe sampled outside IDLE with pending=0 SHALL capture mem_map_io into the holding register and set pending.
REQ-018 A strobe sampled with pending=1 SHALL drop the new word, leave the holding register unchanged, and set overflow.
REQ-019 When the 4th stop bit completes and pending=1, the block SHALL move the holding word into the shift register, clear pending, and enter START with no idle gap.
REQ-020 When a strobe coincides with the cycle in which pending is freed (REQ-019), the block SHALL capture the strobe word into the holding register with no overflow.
REQ-021 When a strobe coincides with the final stop-bit completion and pending=0, the block SHALL capture the strobe word into the holding register and enter START the next cycle, with no overflow.
REQ-022 words_sent SHALL increment by 1 on completion of the 4th stop bit of each word.
REQ-023 When ovf_clr and an overflowing strobe occur in the same cycle, set SHALL take priority: overflow=1.
REQ-024 busy SHALL be low only in IDLE with pending=0.
REQ-025 tx SHALL be driven from a register (glitch-free).

Reset
REQ-026 Asserting rst SHALL immediately force the following, regardless of clk, including mid-frame:
- tx=1, busy=0, pending=0, overflow=0, words_sent=0;
- FSM=IDLE; all counters and the shift/holding registers cleared.
REQ-027 After rst deasserts, the first strobe SHALL be accepted exactly as in REQ-016.

Verification (CLKS_PER_BIT=4)
REQ-028 Single word:
- Stimulus: strobe with 0x000000A5.
- Response: tx low 1 cycle later; byte 0 bits 1,0,1,0,0,1,0,1; bytes 1-3 are 0x00; 160 cycles total; then busy=0 and words_sent=1.
REQ-029 Back-to-back:
- Stimulus: 0x11223344, then 0xDEADBEEF strobed 10 cycles later.
- Response: pending=1; byte sequence 44,33,22,11,EF,BE,AD,DE with no idle gap between words; words_sent=2; overflow=0.
REQ-030 Overflow:
- Stimulus: three strobes while busy (0x1, 0x2, 0x3).
- Response: 0x3 is dropped; overflow=1; only 0x1 and 0x2 are transmitted.
- Then: ovf_clr pulse -> overflow=0.
REQ-031 Coincidence:
- Stimulus: strobe exactly on the final stop-bit completion cycle, with pending=1 and with pending=0.
- Response: both cases have no overflow and the word is sent next.
REQ-032 Reset mid-frame:
- Stimulus: assert rst during byte 2 data bits.
- Response: tx=1 and all outputs zero before the next clk edge.
- Then: a fresh strobe of 0x000000FF transmits correctly.
REQ-033 Wrap: preset traffic until words_sent=0xFFFF; one more word -> words_sent=0x0000.
